// File: rtl/word_unpacker.sv
// word_unpacker: splits one NUM_LANES*LANE_W word into a LANE_W lane stream.
// Define WORD_UNPACK_KEEP_EN to add the in_keep per-lane emit mask.
module word_unpacker #(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 8
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [NUM_LANES*LANE_W-1:0]                  in_data,
`ifdef WORD_UNPACK_KEEP_EN
    input  logic [NUM_LANES-1:0]                         in_keep,
`endif
    input  logic                                         in_valid,
    output logic                                         in_ready,
    output logic [LANE_W-1:0]                            out_data,
    output logic [(NUM_LANES>1 ? $clog2(NUM_LANES):1)-1:0] out_lane,
    output logic                                         out_last,
    output logic                                         out_valid,
    input  logic                                         out_ready
);

    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]                  state;
    logic [NUM_LANES*LANE_W-1:0] word_q;
    logic [NUM_LANES-1:0]        keep_q;
    logic [NUM_LANES-1:0]        keep_in;
    logic [LW-1:0]               lane_q;
    logic [LW-1:0]               first_lane;
    logic [LW-1:0]               nxt_lane;
    logic                        first_found;
    logic                        nxt_found;
    logic                        fire;
    logic                        accept;
    logic                        load;

`ifdef WORD_UNPACK_KEEP_EN
    assign keep_in = in_keep;
`else
    assign keep_in = '1;
`endif

    // Lowest lane set in the incoming mask; none set means drop the word
    always_comb begin
        first_lane  = '0;
        first_found = 1'b0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (keep_in[i]) begin
                first_lane  = LW'(i);
                first_found = 1'b1;
            end
        end
    end

    // Next kept lane strictly above the current one; none means this is last
    always_comb begin
        nxt_lane  = lane_q;
        nxt_found = 1'b0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (keep_q[i] && (i > int'(lane_q))) begin
                nxt_lane  = LW'(i);
                nxt_found = 1'b1;
            end
        end
    end

    // Select the current lane out of the stored word
    always_comb begin
        out_data = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_q == LW'(i)) begin
                out_data = word_q[i*LANE_W +: LANE_W];
            end
        end
    end

    assign out_valid = (state == SEND) && !rst;
    assign out_lane  = lane_q;
    assign out_last  = out_valid && !nxt_found;
    assign fire      = out_valid && out_ready;
    assign in_ready  = !rst && ((state == IDLE) || (fire && out_last));
    assign accept    = in_valid && in_ready;
    assign load      = accept && first_found;

    // Lane sequencing: advance, reload on the final handshake, or go idle
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            word_q <= '0;
            keep_q <= '0;
            lane_q <= '0;
        end else if (fire && !out_last) begin
            lane_q <= nxt_lane;
        end else if (load) begin
            word_q <= in_data;
            keep_q <= keep_in;
            lane_q <= first_lane;
            state  <= SEND;
        end else if (fire) begin
            state  <= IDLE;
        end
    end

endmodule

// File: doc/word_unpacker.md
WORD_UNPACKER -- requirements
Module: word_unpacker

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, number of byte lanes per input word.
REQ-002 SHALL have parameter LANE_W, default 8, bits per lane.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_data, input, NUM_LANES*LANE_W, word to unpack; lane i = in_data[i*LANE_W +: LANE_W].
REQ-006 SHALL have port in_valid, input, 1, in_data valid.
REQ-007 SHALL have port in_ready, output, 1, word accepted when in_valid & in_ready.
REQ-008 SHALL have port out_data, output, LANE_W, current lane.
REQ-009 SHALL have port out_lane, output, clog2(NUM_LANES), lane index of out_data.
REQ-010 SHALL have port out_last, output, 1, marks final emitted lane of a word.
REQ-011 SHALL have port out_valid, output, 1, out_data/out_lane/out_last valid.
REQ-012 SHALL have port out_ready, input, 1, lane consumed when out_valid & out_ready.
REQ-013 SHALL have port in_keep, input, NUM_LANES, per-lane emit mask; present only with WORD_UNPACK_KEEP_EN.

Function
REQ-014 SHALL implement FSM with states IDLE and SEND.
REQ-015 IDLE: in_ready=1, out_valid=0; on accept, register word (and keep), load lane index with first lane to emit, go SEND.
REQ-016 SHALL present first lane with out_valid=1 the cycle after acceptance (1-cycle latency).
REQ-017 SEND: emit lanes in ascending index order, lane 0 first; advance index only on out_valid & out_ready.
REQ-018 out_data, out_lane, out_last SHALL be held stable while out_valid & !out_ready.
REQ-019 out_last SHALL be 1 only on the final emitted lane of the word.
REQ-020 in_ready SHALL be 1 in SEND exactly when out_valid & out_ready & out_last (zero-bubble back-to-back words).
REQ-021 On final lane consumed with simultaneous new accept, SHALL load new word and stay SEND; without accept, return IDLE.
REQ-022 in_ready SHALL be 0 in SEND otherwise; in_data changes while in_ready=0 SHALL be ignored.
REQ-023 Lane index SHALL never exceed NUM_LANES-1; no wrap-around into stale lanes.

Reset
REQ-024 While rst=1 at a clock edge: state=IDLE, out_valid=0, out_data=0, out_lane=0, out_last=0, stored word=0.
REQ-025 in_ready SHALL be 0 during any cycle rst=1 and 1 the first cycle after rst deasserts.
REQ-026 Reset asserted mid-word SHALL discard remaining lanes; no lane emitted after reset.

Configuration
REQ-027 Macro WORD_UNPACK_KEEP_EN SHALL compile in the in_keep lane mask.
REQ-028 With macro: lanes with in_keep[i]=0 SHALL be skipped with no idle cycle; out_last on highest set lane.
REQ-029 With macro: word with in_keep=0 SHALL be accepted and dropped, no output, FSM stays IDLE.
REQ-030 Without macro: in_keep absent, all NUM_LANES lanes emitted, out_last on lane NUM_LANES-1.

Verification
REQ-031 Reset then in_data=32'hDDCCBBAA one cycle, out_ready=1 -> out_data AA,BB,CC,DD on cycles 1-4, out_lane 0-3, out_last only with DD.
REQ-032 Two words 32'h03020100 then 32'h07060504 held valid, out_ready=1 -> 8 consecutive bytes 00..07, no bubble, in_ready pulses with byte 03.
REQ-033 out_ready=0 for 3 cycles on lane 1 of 32'h44332211 -> out_data=22, out_lane=1 held stable, in_ready=0, then 33,44 resume.
REQ-034 rst=1 after lane 1 of 32'hDEADBEEF emitted -> out_valid=0 next cycle, no AD/DE emitted, in_ready=1 after rst release.
REQ-035 (KEEP_EN) in_keep=4'b1010, in_data=32'hDDCCBBAA -> BB (lane 1), DD (lane 3, out_last) on consecutive cycles; in_keep=4'b0000 -> no output.
